// File: rtl/uart_pkg.sv
// Shared UART definitions: baud divider presets, frame length, receiver states
// and a constant-foldable ceil(log2) used to size counters.
package uart_pkg;

   localparam int unsigned BAUD_9600_50M   = 5208;
   localparam int unsigned BAUD_115200_50M = 434;
   localparam int unsigned FRAME_BITS      = 10;

   typedef enum logic {
      IDLE = 1'b0,
      RECV = 1'b1
   } rx_state_e;

   // Bits needed to hold values 0..value-1
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned r;
      r = 0;
      for (int unsigned w = value - 1; w != 0; w = w >> 1) begin
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Three-flop synchronizer for an asynchronous serial line with falling-edge
// detect; flops reset to the idle (high) level so release never looks like a start.
module uart_rx_sync (
   input  logic clk,
   input  logic rst,
   input  logic rx,
   output logic level,
   output logic fall
);

   logic r1;
   logic r2;
   logic r3;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r1 <= 1'b1;
         r2 <= 1'b1;
         r3 <= 1'b1;
      end else begin
         r1 <= rx;
         r2 <= r1;
         r3 <= r2;
      end
   end

   assign level = r2;
   assign fall  = !r2 && r3;

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: mid-bit sampling from a baud counter, one-cycle strobes
// for a good byte (flag_rx_end) or a bad stop bit (frame_err).
module uart_rx_byte
   import uart_pkg::*;
#(
   parameter int unsigned BAUD_END = BAUD_9600_50M,
   parameter int unsigned HALF_END = BAUD_END / 2 - 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rs232_rx,
   output logic [7:0] rx_data,
   output logic       flag_rx_end,
   output logic       frame_err,
   output logic       rx_busy
);

   localparam int unsigned CNT_W = clog2(BAUD_END);
   localparam int unsigned BIT_W = clog2(FRAME_BITS);

   rx_state_e        state;
   logic [CNT_W-1:0] cnt_baud;
   logic [BIT_W-1:0] bit_cnt;
   logic [7:0]       shift;
   logic             line;
   logic             fall;
   logic             sample;

   uart_rx_sync u_sync (
      .clk   (clk),
      .rst   (rst),
      .rx    (rs232_rx),
      .level (line),
      .fall  (fall)
   );

   assign sample  = (state == RECV) && (cnt_baud == CNT_W'(HALF_END));
   assign rx_busy = (state == RECV);

   // Returning to IDLE right after the stop sample leaves half a bit to catch
   // the next start edge, so back-to-back frames need no idle gap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         cnt_baud    <= '0;
         bit_cnt     <= '0;
         shift       <= '0;
         rx_data     <= '0;
         flag_rx_end <= 1'b0;
         frame_err   <= 1'b0;
      end else begin
         flag_rx_end <= 1'b0;
         frame_err   <= 1'b0;
         case (state)
            IDLE: begin
               cnt_baud <= '0;
               bit_cnt  <= '0;
               if (fall) begin
                  state <= RECV;
               end
            end
            RECV: begin
               cnt_baud <= (cnt_baud == CNT_W'(BAUD_END - 1)) ? '0 : cnt_baud + CNT_W'(1);
               if (sample) begin
                  bit_cnt <= bit_cnt + BIT_W'(1);
                  if (bit_cnt == '0) begin
                     // High start sample means a glitch, not a frame
                     if (line) begin
                        state    <= IDLE;
                        bit_cnt  <= '0;
                        cnt_baud <= '0;
                     end
                  end else if (bit_cnt == BIT_W'(FRAME_BITS - 1)) begin
                     state    <= IDLE;
                     bit_cnt  <= '0;
                     cnt_baud <= '0;
                     if (line) begin
                        rx_data     <= shift;
                        flag_rx_end <= 1'b1;
                     end else begin
                        frame_err <= 1'b1;
                     end
                  end else begin
                     shift <= {line, shift[7:1]};
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx_byte.sv
// Scoreboarded bench for uart_rx_byte at 16 clocks per bit: stimulus pushes
// expected strobes, a negedge monitor pops and compares them.
module tb_uart_rx_byte;

   localparam int BAUD    = 16;
   localparam int HALF    = BAUD / 2 - 1;
   localparam int CLK_P   = 10;
   localparam int BIT_T   = BAUD * CLK_P;
   // line change -> 2 sync flops -> state entry -> mid-bit -> 9 more bits -> strobe
   localparam int LATENCY = 2 + 1 + HALF + 9 * BAUD + 1;

   typedef struct {
      logic       err;
      logic [7:0] data;
      int         cyc;
   } exp_t;

   logic       clk;
   logic       rst;
   logic       rs232_rx;
   logic [7:0] rx_data;
   logic       flag_rx_end;
   logic       frame_err;
   logic       rx_busy;

   exp_t       sb[$];
   int         checks;
   int         errors;
   int         cyc;
   logic [7:0] model_rx;
   logic       prev_flag;
   logic       prev_err;

   uart_rx_byte #(.BAUD_END(BAUD), .HALF_END(HALF)) dut (
      .clk         (clk),
      .rst         (rst),
      .rs232_rx    (rs232_rx),
      .rx_data     (rx_data),
      .flag_rx_end (flag_rx_end),
      .frame_err   (frame_err),
      .rx_busy     (rx_busy)
   );

   initial clk = 1'b0;
   always #(CLK_P / 2) clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      checks = checks + 1;
      if (act != exp) begin
         errors = errors + 1;
         $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   // Drive one frame; bit_t is the bit length in time units
   task automatic send_frame(input logic [7:0] b, input logic stop, input int bit_t);
      logic [9:0] fr;
      fr = {stop, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         rs232_rx = fr[i];
         #(bit_t);
      end
   endtask

   task automatic expect_send(input logic [7:0] b, input logic stop, input int bit_t,
                              input bit timed);
      exp_t e;
      e.err  = !stop;
      e.data = b;
      e.cyc  = timed ? cyc + LATENCY : -1;
      sb.push_back(e);
      send_frame(b, stop, bit_t);
   endtask

   task automatic align();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every strobe must match the head of the scoreboard
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         model_rx  = 8'h00;
         prev_flag = 1'b0;
         prev_err  = 1'b0;
      end else begin
         if (flag_rx_end || frame_err) begin
            check("strobe_exclusive", int'(flag_rx_end & frame_err), 0);
            check("strobe_single_cycle", int'(prev_flag | prev_err), 0);
            if (sb.size() == 0) begin
               checks = checks + 1;
               errors = errors + 1;
               $display("FAIL unexpected_strobe: flag=%0b err=%0b data=0x%0h at cycle %0d",
                        flag_rx_end, frame_err, rx_data, cyc);
            end else begin
               e = sb.pop_front();
               check("strobe_kind_err", int'(frame_err), int'(e.err));
               if (e.cyc >= 0) check("strobe_cycle", cyc, e.cyc);
               if (!e.err) model_rx = e.data;
               check("rx_data", int'(rx_data), int'(model_rx));
            end
         end
         prev_flag = flag_rx_end;
         prev_err  = frame_err;
      end
   end

   initial begin
      #(CLK_P * 100000);
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      int busy_cnt;
      int bit_t;
      int gap;
      logic [7:0] b;
      logic [7:0] burst [5];
      checks   = 0;
      errors   = 0;
      rst      = 1'b1;
      rs232_rx = 1'b1;
      burst    = '{8'h55, 8'h12, 8'h34, 8'h56, 8'hAA};

      repeat (3) @(negedge clk);
      check("reset_rx_data", int'(rx_data), 0);
      check("reset_flag", int'(flag_rx_end), 0);
      check("reset_err", int'(frame_err), 0);
      check("reset_busy", int'(rx_busy), 0);
      align();
      rst = 1'b0;
      repeat (10) align();

      // Single timed frame
      expect_send(8'h55, 1'b1, BIT_T, 1'b1);
      repeat (20) align();

      // Back-to-back burst, no idle between frames
      for (int i = 0; i < 5; i++) expect_send(burst[i], 1'b1, BIT_T, 1'b1);
      repeat (20) align();

      // Short glitch must abort without a strobe
      busy_cnt = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (i == 0) rs232_rx = 1'b0;
         if (i == 4) rs232_rx = 1'b1;
         busy_cnt += int'(rx_busy);
      end
      check("glitch_busy_seen", int'(busy_cnt >= 1), 1);
      check("glitch_busy_short", int'(busy_cnt <= 9), 1);
      align();
      expect_send(8'hA5, 1'b1, BIT_T, 1'b1);
      repeat (20) align();

      // Bad stop bit
      expect_send(8'h3C, 1'b0, BIT_T, 1'b1);
      rs232_rx = 1'b1;
      repeat (20) align();
      check("after_bad_stop_data", int'(rx_data), 8'hA5);

      // Break: one frame_err, then silence while line stays low
      begin
         exp_t e;
         e.err  = 1'b1;
         e.data = 8'h00;
         e.cyc  = cyc + LATENCY;
         sb.push_back(e);
      end
      rs232_rx = 1'b0;
      repeat (400) align();
      check("break_idle", int'(rx_busy), 0);
      rs232_rx = 1'b1;
      repeat (20) align();

      // Reset in the middle of data bit 4 of 0xFF
      send_frame(8'hFF, 1'b1, 0);
      rs232_rx = 1'b0;
      #(BIT_T);
      for (int i = 0; i < 4; i++) begin
         rs232_rx = 1'b1;
         #(BIT_T);
      end
      #(BIT_T / 2);
      check("mid_frame_busy", int'(rx_busy), 1);
      rst = 1'b1;
      #1;
      check("async_rst_data", int'(rx_data), 0);
      check("async_rst_flag", int'(flag_rx_end), 0);
      check("async_rst_err", int'(frame_err), 0);
      check("async_rst_busy", int'(rx_busy), 0);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (20) align();
      check("post_rst_idle", int'(rx_busy), 0);
      expect_send(8'h81, 1'b1, BIT_T, 1'b1);
      repeat (20) align();

      // Skewed bit period, random bytes
      for (int i = 0; i < 20; i++) begin
         b     = 8'($urandom);
         bit_t = ($urandom_range(0, 1) == 1) ? (BIT_T * 97 / 100) : (BIT_T * 103 / 100);
         gap   = $urandom_range(0, 30);
         #(gap);
         expect_send(b, 1'b1, bit_t, 1'b0);
      end
      rs232_rx = 1'b1;
      repeat (200) align();

      check("scoreboard_drained", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_rx_byte.md
Name: uart_rx_byte

Overview:
- Serial receive front end of the UART-to-SDRAM path.
- Oversamples the asynchronous RS-232 line (8N1, LSB first) with a baud counter and recovers one byte per frame.
- Per good frame: presents the byte on rx_data and pulses flag_rx_end for one cycle.
- Directly feeds the command decoder: 0x55 starts a 4-byte write burst, 0xAA triggers a read.

Parameters:
- BAUD_END, 5208, clk cycles per bit (50 MHz / 9600). Must be ≥ 8. Sim uses 16.
- HALF_END, BAUD_END/2-1, cnt_baud value at which a bit is sampled (mid-bit).

Ports:
- clk  in  1  system clock, single domain.
- rst  in  1  asynchronous, active-high reset.
- rs232_rx  in  1  raw serial line, asynchronous, idle high.
- rx_data  out  8  last correctly framed byte; stable until the next good frame.
- flag_rx_end  out  1  one-cycle strobe; rx_data is valid in the same cycle.
- frame_err  out  1  one-cycle strobe on a bad stop bit.
- rx_busy  out  1  high while a frame is being received.

Behaviour:
- Reset: async, active-high. Clears every register. rx_data=0, flag_rx_end=0, frame_err=0, rx_busy=0. Synchronizer flops reset to 1 (idle line).
- Synchronizer: rs232_rx passes through 3 flops r1→r2→r3. Falling edge fall = !r2 && r3.
- States: IDLE, RECV (held as rx_busy flag).
  - IDLE→RECV on fall. fall is ignored while in RECV.
- cnt_baud, width clog2(BAUD_END):
  - Counts 0..BAUD_END-1 while in RECV, then wraps to 0.
  - Cleared in IDLE.
  - Starts at 0 in the first RECV cycle.
- Sample strobe: when in RECV and cnt_baud==HALF_END, sample r2 into bit slot bit_cnt, then increment bit_cnt (0..9).
  - bit_cnt 0 = start, 1..8 = data LSB first, 9 = stop.
- Timing: let E be the cycle with fall. Bit k is sampled at E+1+HALF_END+k*BAUD_END.
- False start: start sample (bit_cnt 0) reads 1 → return to IDLE next cycle. No strobe, rx_data unchanged.
- Shift register: data samples shift into shift[7:0] from the MSB side. After bit 8, shift holds the byte LSB-correct.
- Stop sample (bit_cnt 9), always followed by IDLE next cycle with bit_cnt=0 and cnt_baud=0:
  - Reads 1: next cycle rx_data<=shift and flag_rx_end=1 for exactly one cycle.
  - Reads 0: next cycle frame_err=1 for one cycle; rx_data unchanged.
  - Early IDLE is intentional: the next start edge is caught with half a bit of margin.
- Latency: flag_rx_end is high at cycle E+2+HALF_END+9*BAUD_END.
- Back-to-back frames with zero idle time are received without loss.
- flag_rx_end and frame_err are mutually exclusive and never high on consecutive cycles from the same frame.
- Line held low (break): produces frame_err. No new frame starts until the line returns high and falls again.
- Reset mid-frame: frame is discarded, no strobe. Receiver re-arms on the next falling edge after release.
- rx_busy = RECV state.

Decomposition:
- Shared package uart_pkg:
  - BAUD_9600_50M=5208, BAUD_115200_50M=434.
  - Function clog2 for counter width.
  - FRAME_BITS=10 constant.
- Sub-module uart_rx_sync: 3-flop synchronizer plus falling-edge detect.
  - Outputs: the synchronized level (r2) and fall.
  - Reset value 1.
  - Reusable by a future uart_tx loopback checker.

Test Plan (BAUD_END=16, HALF_END=7):
1. Reset then 8N1 frame of 0x55 → rx_data=0x55; flag_rx_end high for exactly 1 cycle at E+2+7+144 = E+153; frame_err stays 0.
2. Frames 0x55, 0x12, 0x34, 0x56, 0xAA sent back-to-back, no idle → five strobes with those values in order, spacing 160 cycles.
3. Line low for 4 cycles then high (glitch) → false start aborts; no strobe; rx_busy high for ≤ 9 cycles. A following 0xA5 frame is received correctly.
4. Frame 0x3C with stop bit driven 0 → frame_err one-cycle pulse, flag_rx_end 0, rx_data keeps the previous value (0xA5).
5. rst asserted for 3 cycles during data bit 4 of 0xFF → all outputs 0 immediately. A subsequent 0x81 frame is received with a single strobe.
6. Bit period skewed ±3% (bit length 15.5/16.5 cycles, jittered) across 20 random bytes → all bytes match, no frame_err.
